// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute control FSM for a single-bus datapath.
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Run,
  input  logic        Mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        Zlowout,
  output logic        Rout,
  output logic        Rin,
  output logic [3:0]  Rout_sel,
  output logic [3:0]  Rin_sel,
  output logic [4:0]  ALU_op,
  output logic        Busy,
  output logic        Halted
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;
  state_t state;
  logic [4:0] opcode;
  logic alu_fmt, is_halt;
  assign opcode  = IR[31:27];
  assign alu_fmt = opcode >= 5'b00011 && opcode <= 5'b01100;
  assign is_halt = opcode == 5'b11010;
  always_ff @(posedge Clock or negedge Clear)
    if (!Clear) state <= IDLE;
    else
      case (state)
        IDLE:    state <= Run ? T0 : IDLE;
        T0:      state <= T1;
        T1:      state <= Mem_ready ? T2 : T1;
        T2:      state <= T3;
        T3:      state <= alu_fmt ? T4 : is_halt ? HALT : Run ? T0 : IDLE;
        T4:      state <= T5;
        T5:      state <= Run ? T0 : IDLE;
        default: state <= HALT;
      endcase
  // IDLE decodes to all-zero, so the async Clear also clears every output
  assign PCout    = state == T0;
  assign MARin    = state == T0;
  assign IncPC    = state == T0;
  assign Read     = state == T1;
  assign MDRin    = state == T1 && Mem_ready;
  assign MDRout   = state == T2;
  assign IRin     = state == T2;
  assign Yin      = state == T3 && alu_fmt;
  assign ZLowIn   = state == T4;
  assign Zlowout  = state == T5;
  assign Rout     = Yin || state == T4;
  assign Rin      = state == T5;
  assign Rout_sel = Yin ? IR[22:19] : state == T4 ? IR[18:15] : 4'd0;
  assign Rin_sel  = Rin ? IR[26:23] : 4'd0;
  assign ALU_op   = state == T4 ? opcode : 5'd0;
  assign Busy     = state != IDLE && state != HALT;
  assign Halted   = state == HALT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized check of control_sequencer against a cycle-offset model.
module tb_control_sequencer;
  logic Clock, Clear, Run, Mem_ready;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, Zlowout, Rout, Rin, Busy, Halted;
  logic [3:0] Rout_sel, Rin_sel;
  logic [4:0] ALU_op;
  logic [26:0] dut_vec;
  int checks = 0, errors = 0;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .Zlowout(Zlowout),
    .Rout(Rout), .Rin(Rin), .Rout_sel(Rout_sel), .Rin_sel(Rin_sel), .ALU_op(ALU_op),
    .Busy(Busy), .Halted(Halted)
  );

  assign dut_vec = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, Zlowout,
                    Rout, Rin, Rout_sel, Rin_sel, ALU_op, Busy, Halted};

  initial Clock = 0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {logic [31:0] ir; int w; bit rst4;} plan_t;
  plan_t plan[$];
  // mode 0 idle, 1 executing (k = cycle offset in instruction), 2 halted
  int mode = 0, k = 0, w = 0, hcnt = 0;
  logic [31:0] ins = 0;
  bit dir = 0, rst4 = 0;

  function automatic bit is_alu(input logic [31:0] i);
    return i[31:27] >= 5'd3 && i[31:27] <= 5'd12;
  endfunction

  function automatic int ins_len();
    return is_alu(ins) ? w + 6 : w + 4;
  endfunction

  function automatic logic [26:0] expect_out();
    logic [11:0] ctl = 0;
    logic [3:0] rs = 0, ri = 0;
    logic [4:0] op = 0;
    if (mode == 2) return 27'd1;
    if (mode == 0) return 27'd0;
    if (k == 0) ctl = 12'b111000000000;
    else if (k <= w + 1) ctl = {3'b000, 1'b1, k == w + 1, 7'b0};
    else if (k == w + 2) ctl = 12'b000001100000;
    else if (k == w + 3 && is_alu(ins)) begin ctl = 12'b000000010010; rs = ins[22:19]; end
    else if (k == w + 4) begin ctl = 12'b000000001010; rs = ins[18:15]; op = ins[31:27]; end
    else if (k == w + 5) begin ctl = 12'b000000000101; ri = ins[26:23]; end
    return {ctl, rs, ri, op, 1'b1, 1'b0};
  endfunction

  task automatic start_instr();
    plan_t p;
    mode = 1; k = 0;
    if (plan.size() > 0) begin
      p = plan.pop_front();
      ins = p.ir; w = p.w; rst4 = p.rst4; dir = 1;
    end else begin
      ins = $urandom; w = $urandom_range(0, 4); rst4 = 0; dir = 0;
    end
  endtask

  initial begin
    bit do_rst;
    Clear = 0; Run = 0; Mem_ready = 0; IR = 0;
    plan.push_back('{32'h4A920000, 0, 0});
    plan.push_back('{32'h4A920000, 3, 0});
    plan.push_back('{32'h00000000, 1, 0});
    plan.push_back('{32'h4A920000, 0, 1});
    plan.push_back('{32'hD0000000, 0, 0});
    #12;
    check("reset", dut_vec, 0);
    @(negedge Clock);
    Clear = 1;
    repeat (4000) begin
      Run = (mode != 2 && (plan.size() > 0 || dir)) ? 1'b1 : ($urandom % 4 != 0);
      Mem_ready = (mode == 1 && k >= 1 && k <= w + 1) ? (k == w + 1) : 1'($urandom % 2);
      IR = (mode == 1 && k >= w + 3) ? ins : $urandom;
      #1;
      check("outs", dut_vec, expect_out());
      check("one_driver", $countones({PCout, MDRout, Rout, Zlowout}) <= 1, 1);
      do_rst = (mode == 1 && rst4 && k == w + 4) || (mode == 2 && hcnt >= 4) || ($urandom % 300 == 0);
      if (do_rst) begin
        #1 Clear = 0;
        #1 check("clear", dut_vec, 0);
        Clear = 1;
        mode = 0; rst4 = 0; dir = 0; hcnt = 0;
      end
      @(posedge Clock);
      if (mode == 0) begin
        if (Run) start_instr();
      end else if (mode == 1) begin
        if (k == ins_len() - 1) begin
          if (ins[31:27] == 5'b11010) begin mode = 2; hcnt = 0; end
          else if (Run) start_instr();
          else begin mode = 0; dir = 0; end
        end else k++;
      end else hcnt++;
      @(negedge Clock);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have port Clock, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-002 The block SHALL have port Clear, input, 1 bit: the reset, asynchronous and active-low.
REQ-003 The block SHALL have port Run, input, 1 bit: start and continue fetch/execute cycles while high.
REQ-004 The block SHALL have port Mem_ready, input, 1 bit: memory read data is valid on Mdatain this cycle.
REQ-005 The block SHALL have port IR, input, 32 bits: the datapath instruction register contents.
REQ-006 The block SHALL have outputs PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn and Zlowout, each 1 bit, driving the datapath control lines of the same names.
REQ-007 The block SHALL have outputs Rout and Rin, each 1 bit: the general-register bus-drive and load enables.
REQ-008 The block SHALL have outputs Rout_sel and Rin_sel, each 4 bits: the register index for Rout and Rin.
REQ-009 The block SHALL have output ALU_op, 5 bits: the ALU operation code, 0 when not in T4.
REQ-010 The block SHALL have outputs Busy and Halted, each 1 bit: Busy is high in T0-T5; Halted is high in the HALT state.

Function
REQ-011 The state SHALL be one of IDLE, T0, T1, T2, T3, T4, T5 or HALT, registered, with every output decoded from the state and IR only (Moore outputs, plus a Mem_ready term in T1).
REQ-012 IR fields SHALL be: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
REQ-013 In IDLE, the state SHALL move to T0 when Run=1 and otherwise stay in IDLE.
REQ-014 T0 SHALL assert PCout, MARin and IncPC for exactly one cycle, then move to T1.
REQ-015 T1 SHALL assert Read every cycle; MDRin SHALL equal Mem_ready; the state SHALL stay in T1 while Mem_ready=0 and move to T2 in the first cycle Mem_ready=1.
REQ-016 T2 SHALL assert MDRout and IRin for one cycle; IR SHALL be treated as valid from T3 onward.
REQ-017 At T3, if the opcode is in the R-format range 5'b00011 to 5'b01100 inclusive, T3 SHALL assert Rout with Rout_sel=Rb, and Yin.
REQ-018 At T3, if the opcode is 5'b11010 (halt), the next state SHALL be HALT with no control asserted.
REQ-019 At T3, for any other opcode (nop/unsupported), the next state SHALL be T0 if Run=1 and IDLE otherwise, with no control asserted.
REQ-020 T4 SHALL assert Rout with Rout_sel=Rc, set ALU_op to the opcode, and assert ZLowIn.
REQ-021 T5 SHALL assert Zlowout and Rin with Rin_sel=Ra.
REQ-022 After T5, the next state SHALL be T0 if Run=1 and IDLE otherwise.
REQ-023 Rout_sel and Rin_sel SHALL be 0 whenever Rout and Rin respectively are low.
REQ-024 At most one bus driver (PCout, MDRout, Rout, Zlowout) SHALL be asserted in any cycle.
REQ-025 HALT SHALL be absorbing: only Clear exits it, and Run is ignored there.
REQ-026 A Run deassertion mid-instruction SHALL NOT abort the instruction; it is sampled only at IDLE, at T3 (non-ALU opcodes) and at T5.
REQ-027 Minimum instruction latency (Mem_ready=1 on the first T1 cycle) SHALL be 6 cycles T0-T5.

Reset
REQ-028 Clear=0 SHALL immediately force IDLE and drive every output to 0, regardless of clock or current state, including mid-T1 wait and HALT.
REQ-029 On Clear release, the first state transition SHALL occur on the next rising edge, and only if Run=1.

Verification
REQ-030 Scenario 1, ROR: Run=1, Mem_ready=1, IR=32'h4A920000 -> T3: Rout=1, Rout_sel=2, Yin=1; T4: Rout_sel=4, ALU_op=5'b01001, ZLowIn=1; T5: Zlowout=1, Rin=1, Rin_sel=5; Busy high for 6 cycles.
REQ-031 Scenario 2, memory wait: Mem_ready held 0 for 3 cycles in T1 -> Read=1 and MDRin=0 for those 3 cycles; MDRin=1 and exit to T2 on the 4th cycle; total latency 9 cycles.
REQ-032 Scenario 3, halt: IR=32'hD0000000 -> T3 then HALT; Halted=1 and Busy=0 until Clear, with Run toggling ignored.
REQ-033 Scenario 4, nop: IR=32'h00000000 with Run=1 -> T0-T3 then T0, with no Yin, ZLowIn or Rin asserted.
REQ-034 Scenario 5, reset mid-operation: Clear pulsed low during T4 -> all outputs 0 with no clock edge; IDLE after release; restart at T0 on the next edge with Run=1.
REQ-035 Scenario 6, one driver: across all scenarios, a checker SHALL confirm at most one of PCout, MDRout, Rout, Zlowout is high per cycle.
